// File: rtl/div_chk_pkg.sv
// Shared types and constants for the divide-by-N ratio checker.
package div_chk_pkg;

    typedef enum logic [1:0] {
        HUNT,
        MEAS,
        LOCKED,
        STALL
    } chk_state_t;

    localparam int         ERR_W     = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    // A waveform already high at reset release must not look like an edge.
    localparam logic       D_Q_RESET = 1'b1;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for the sampled divided waveform.
module rise_detect
    import div_chk_pkg::*;
(
    input  logic clk,
    input  logic RESET,
    input  logic D,
    output logic rise
);

    logic d_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (RESET) d_q <= D_Q_RESET;
        else       d_q <= D;
    end

    assign rise = D & ~d_q;

endmodule

// File: rtl/divide_ratio_checker.sv
// Measures period and high time of D and tracks lock/stall against an expected divide-by-N.
module divide_ratio_checker
    import div_chk_pkg::*;
#(
    parameter int N          = 3,
    parameter int CW         = 8,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 2 * N
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             D,
    output logic [CW-1:0]    period,
    output logic [CW-1:0]    high_time,
    output logic             meas_valid,
    output logic             match,
    output logic             locked,
    output logic             stall,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int            RW        = $clog2(LOCK_COUNT + 1);
    localparam logic [CW-1:0] N_V       = CW'(N);
    localparam logic [CW-1:0] TIMEOUT_V = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [RW-1:0] LOCK_LAST = RW'(LOCK_COUNT - 1);

    logic          rise;
    logic [CW-1:0] cnt, hcnt;
    logic [RW-1:0] run_q, run_d;
    chk_state_t    state_q, state_d;
    logic          take, err_inc, good;

    rise_detect u_rise (
        .clk   (clk),
        .RESET (RESET),
        .D     (D),
        .rise  (rise)
    );

    // Counters hold the running period; their pre-load values are the measurement.
    always_ff @(posedge clk) begin
        if (RESET) begin
            cnt  <= '0;
            hcnt <= '0;
        end else if (rise) begin
            cnt  <= CW'(1);
            hcnt <= CW'(1);
        end else begin
            if (cnt != CNT_MAX)      cnt  <= cnt + 1'b1;
            if (D && hcnt != CNT_MAX) hcnt <= hcnt + 1'b1;
        end
    end

    assign good = (cnt == N_V) && (hcnt != '0) && (hcnt < N_V);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        take    = 1'b0;
        err_inc = 1'b0;
        unique case (state_q)
            HUNT: begin
                if (rise) begin
                    state_d = MEAS;
                    run_d   = '0;
                end
            end
            MEAS, LOCKED: begin
                if (rise) begin
                    take = 1'b1;
                    if (good) begin
                        if (state_q == MEAS) begin
                            run_d = run_q + 1'b1;
                            if (run_q == LOCK_LAST) state_d = LOCKED;
                        end
                    end else begin
                        state_d = MEAS;
                        run_d   = '0;
                        err_inc = 1'b1;
                    end
                end else if (cnt == TIMEOUT_V) begin
                    state_d = STALL;
                    run_d   = '0;
                    err_inc = 1'b1;
                end
            end
            STALL: begin
                // The period spanning the stall is unknown, so resume without measuring.
                if (rise) begin
                    state_d = MEAS;
                    run_d   = '0;
                end
            end
            default: begin
                state_d = HUNT;
                run_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q <= HUNT;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            match      <= 1'b0;
            err_cnt    <= '0;
        end else begin
            meas_valid <= take;
            if (take) begin
                period    <= cnt;
                high_time <= hcnt;
                match     <= good;
            end
            if (err_inc && err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
        end
    end

    assign locked = (state_q == LOCKED);
    assign stall  = (state_q == STALL);

endmodule

// File: doc/divide_ratio_checker.md
# divide_ratio_checker

Monitor for the output of the divide-by-N clock generators in the FSM lab set: it samples a divided waveform `D` in the `clk` domain, measures the period and high time of every cycle, and reports whether the waveform is a valid divide-by-`N`. It acts as the receiving end of the divider. It sits beside a divider instance in benches or on-chip self-test, and it declares lock only after a run of consecutive good periods.

## Interface
Parameters:
- `N`, 3: expected period of `D` in `clk` cycles; must be ≥ 2.
- `CW`, 8: width of the period and high-time counters.
- `LOCK_COUNT`, 4: consecutive matching periods required for lock; must be ≥ 1.
- `TIMEOUT`, 2*N: number of cycles without a rising edge that declares a stall; must be < 2^CW − 1.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `D`  in  1  divided waveform, synchronous to `clk`.
- `period`  out  CW  last measured period, in cycles.
- `high_time`  out  CW  cycles `D` was 1 within the last measured period.
- `meas_valid`  out  1  one-cycle strobe; `period`, `high_time` and `match` were updated this cycle.
- `match`  out  1  last period was `N` and `high_time` was in 1..N−1.
- `locked`  out  1  lock achieved.
- `stall`  out  1  no rising edge seen for `TIMEOUT` cycles.
- `err_cnt`  out  8  saturating count of mismatching periods since reset.

## Operation
- Rising edge detection: `rise = D & ~d_q`, where `d_q` is `D` registered. `d_q` resets to 1, so a `D` that is already high when reset releases is not taken as an edge.
- Counters:
  - `cnt` loads 1 on `rise`; otherwise it increments, saturating at 2^CW − 1.
  - `hcnt` loads 1 on `rise`; otherwise it increments when `D` = 1, saturating.
- A measurement is `period <= cnt` and `high_time <= hcnt`, taken on `rise`. Both use the pre-load values.
- States:
  - `HUNT`: no reference edge yet. On `rise`, go to `MEAS` with no measurement and `run` = 0.
  - `MEAS`: on `rise`, take a measurement.
    - If it matches, `run++`. When `run` reaches `LOCK_COUNT`, go to `LOCKED`.
    - If it mismatches, `run` = 0 and `err_cnt++`.
  - `LOCKED`: on `rise`, take a measurement. A mismatch deasserts `locked`, sets `run` = 0, increments `err_cnt` and goes to `MEAS`.
  - `STALL`: entered from `MEAS` or `LOCKED` when `cnt` = `TIMEOUT` with no `rise`. Entry clears `locked`, clears `run` and increments `err_cnt` once. The next `rise` returns to `MEAS` with no measurement, since that period is unknown.
- `HUNT` has no timeout.
- `locked` = (state == `LOCKED`). `stall` = (state == `STALL`).
- `err_cnt` saturates at 255.
- `RESET` mid-operation:
  - State returns to `HUNT` and `run` clears.
  - All outputs take their reset values on the next edge.
  - An edge coincident with `RESET` is ignored.

## Timing
- Reset values: `period` = 0, `high_time` = 0, `meas_valid` = 0, `match` = 0, `locked` = 0, `stall` = 0, `err_cnt` = 0.
- `D` sampled high at posedge k with `D` low at posedge k−1: `rise` is seen at posedge k. `meas_valid`, `period`, `high_time` and `match` are registered at posedge k and visible during cycle k..k+1.
- `locked` rises in the same cycle as the `meas_valid` of the `LOCK_COUNT`-th consecutive match. It falls in the same cycle as the mismatching `meas_valid`, or on `STALL` entry.
- `stall` asserts at the posedge where `cnt` would reach `TIMEOUT`, which is `TIMEOUT` cycles after the last `rise`. It deasserts at the posedge that samples the next `rise`.
- `meas_valid` is never asserted on the first `rise` after reset or after a stall.
- Minimum legal period is 2 cycles. A `D` held constant never produces `rise`.

## Structure
- Package `div_chk_pkg` holds:
  - the state enum `chk_state_t` (`HUNT`, `MEAS`, `LOCKED`, `STALL`);
  - the `err_cnt` width constant (8);
  - the localparam for the `d_q` reset value.
- Sub-module `rise_detect` (clk, RESET, D → rise) is the one natural split. The counters and FSM stay in the top level.

## Test plan
- Divide-by-3 source, `D` = 1,0,0 repeating from cycle 2 after reset, `N` = 3:
  - first `rise` gives no `meas_valid`;
  - every later `meas_valid` shows `period` = 3, `high_time` = 1, `match` = 1;
  - `locked` = 1 at the 4th `meas_valid`;
  - `err_cnt` = 0.
- Divide-by-3 source with 2/3 duty (`D` = 1,1,0) → `high_time` = 2, `match` = 1, lock after 4 periods.
- Locked, then one period stretched to 4 cycles:
  - that `meas_valid` shows `period` = 4, `match` = 0;
  - `locked` drops the same cycle and `err_cnt` = 1;
  - relock after 4 more good periods.
- Locked, then `D` held 0:
  - `stall` = 1 exactly 6 cycles after the last `rise`, with `locked` = 0 and `err_cnt` = 1;
  - on `D` resuming, the first `rise` gives no `meas_valid` and `stall` = 0.
- `D` held 1 through reset release, then falling and toggling at period 3 → no spurious `rise` at reset release; normal lock follows.
- `RESET` asserted mid-period while locked → the next cycle shows all outputs 0 and state `HUNT`; after release, the first `rise` gives no measurement.
